// File: rtl/led_scan_ctrl.sv
// LED matrix row-scan controller.
// A double-buffered frame store feeds a blank/show row sequencer. Every row is
// dark for BLANK cycles, then lit for DWELL cycles. Registered outputs are
// computed from the next state, so they line up with the state they describe.

// One row of the frame store: shadow (load side) and active (display side).
module led_scan_row #(
    parameter int COLS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic            swap,
    input  logic [COLS-1:0] ld_row,
    output logic [COLS-1:0] act_n
);
    logic [COLS-1:0] shd_q;
    logic [COLS-1:0] act_q;

    // Active takes the shadow image on a swap edge; the look-ahead value lets
    // the top register col_data for the row it is about to enter.
    always_comb act_n = swap ? shd_q : act_q;

    // Shadow capture on an accepted load; active update on swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_q <= '0;
            act_q <= '0;
        end else begin
            if (ld_en)
                shd_q <= ld_row;
            act_q <= act_n;
        end
    end
endmodule

module led_scan_ctrl #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DWELL = 1024,
    parameter int BLANK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   ld_valid,
    input  logic [ROWS*COLS-1:0]   ld_data,
    output logic                   ld_ready,
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        col_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx,
    output logic                   frame_start
);
    localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAXD = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                     state, state_n;
    logic [TW-1:0]              timer, timer_n;
    logic [IW-1:0]              row_n;
    logic                       frame_n;
    logic                       pending;
    logic                       ld_acc;
    logic                       swap;
    logic [ROWS-1:0][COLS-1:0]  act_n;
    logic [ROWS-1:0]            row_sel_n;
    logic [COLS-1:0]            col_data_n;

    // A new image may only enter the shadow buffer while it is free.
    assign ld_ready = !pending;
    assign ld_acc   = ld_valid && !pending;
    // Swap happens on every entry into row 0 blanking that finds an image waiting.
    assign swap     = frame_n && pending;

    genvar g;
    generate
        for (g = 0; g < ROWS; g++) begin : g_row
            led_scan_row #(.COLS(COLS)) u_row (
                .clk    (clk),
                .rst    (rst),
                .ld_en  (ld_acc),
                .swap   (swap),
                .ld_row (ld_data[g*COLS +: COLS]),
                .act_n  (act_n[g])
            );
        end
    endgenerate

    // Pending flag: set by an accepted load, cleared by the frame swap.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (ld_acc)
            pending <= 1'b1;
        else if (swap)
            pending <= 1'b0;
    end

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            row_idx     <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            row_idx     <= row_n;
            row_sel     <= row_sel_n;
            col_data    <= col_data_n;
            frame_start <= frame_n;
        end
    end

    // Next-state logic: blank/show alternation with a down-counting timer.
    always_comb begin
        state_n = state;
        timer_n = timer;
        row_n   = row_idx;
        frame_n = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
            timer_n = '0;
            row_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_BLANK;
                    timer_n = TW'(BLANK - 1);
                    row_n   = '0;
                    frame_n = 1'b1;
                end
                ST_BLANK: begin
                    if (timer == '0) begin
                        state_n = ST_SHOW;
                        timer_n = TW'(DWELL - 1);
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (timer == '0) begin
                        state_n = ST_BLANK;
                        timer_n = TW'(BLANK - 1);
                        if (row_idx == IW'(ROWS - 1)) begin
                            row_n   = '0;
                            frame_n = 1'b1;
                        end else begin
                            row_n   = row_idx + 1'b1;
                        end
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                    row_n   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state: rows are driven only while showing.
    always_comb begin
        row_sel_n  = '0;
        col_data_n = '0;
        if (state_n == ST_SHOW)
            row_sel_n = {{(ROWS-1){1'b0}}, 1'b1} << row_n;
        if (state_n != ST_IDLE)
            col_data_n = act_n[row_n];
    end

    // At most one row lit, and never outside SHOW.
    always @(posedge clk) begin
        if (!rst)
            assert ($onehot0(row_sel) && (state == ST_SHOW || row_sel == '0))
                else $error("row_sel ghosting: state=%0d row_sel=%b", state, row_sel);
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl at ROWS=4, COLS=8, DWELL=3, BLANK=1.
module tb_led_scan_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int DWELL = 3;
    localparam int BLANK = 1;

    typedef struct packed {
        logic [ROWS-1:0] rs;
        logic [COLS-1:0] cd;
        logic [1:0]      ri;
        logic            fs;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en = 1'b0;
    logic                 ld_valid = 1'b0;
    logic [ROWS*COLS-1:0] ld_data = '0;
    logic                 ld_ready;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic [1:0]           row_idx;
    logic                 frame_start;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;
    exp_t q[$];

    led_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Row drive must never have more than one bit set.
    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if (!$onehot0(row_sel)) begin
                n_err++;
                $display("FAIL onehot row_sel=%b required at most one bit", row_sel);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    // Expected cycles of one full frame: each row blank then shown.
    task automatic push_frame(input logic [ROWS*COLS-1:0] img);
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < BLANK; b++) begin
                e.rs = '0; e.cd = img[r*COLS +: COLS]; e.ri = 2'(r);
                e.fs = (r == 0 && b == 0);
                q.push_back(e);
            end
            for (int d = 0; d < DWELL; d++) begin
                e.rs = 4'(1 << r); e.cd = img[r*COLS +: COLS]; e.ri = 2'(r); e.fs = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t got, e;
        q.delete();
        rst = 1'b1; en = 1'b1; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
        @(negedge clk);
        mon_on = 1'b1;
        got = {row_sel, col_data, row_idx, frame_start};
        n_cmp++;
        if (got !== exp_t'(0)) begin
            n_err++; $display("FAIL reset_outputs got %h required 0", got);
        end
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ld_ready got %b required 1", ld_ready);
        end
        rst = 1'b0; ld_valid = 1'b0; en = 1'b1;
        push_frame('0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL reset_discard cyc %0d got %h required %h", i, got, e);
            end
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t got, e;
        q.delete();
        do_reset();
        ld_data = 32'h0804_0201; ld_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ld_ready !== 1'b0) begin
            n_err++; $display("FAIL basic_pending got ld_ready=%b required 0", ld_ready);
        end
        n_cmp++;
        if ({row_sel, col_data, row_idx, frame_start} !== 15'd0) begin
            n_err++; $display("FAIL basic_idle got %h required 0", {row_sel, col_data, row_idx, frame_start});
        end
        ld_valid = 1'b0; en = 1'b1;
        push_frame(32'h0804_0201);
        push_frame(32'h0804_0201);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL basic cyc %0d got %h required %h", i, got, e);
            end
            if (i == 0) begin
                n_cmp++;
                if (ld_ready !== 1'b1) begin
                    n_err++; $display("FAIL basic_swap_ready got %b required 1", ld_ready);
                end
            end
        end
    endtask

    task automatic test_midload();
        exp_t got, e;
        logic exp_rdy;
        q.delete();
        do_reset();
        ld_data = 32'h0804_0201; ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; en = 1'b1;
        push_frame(32'h0804_0201);
        push_frame(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL midload cyc %0d got %h required %h", i, got, e);
            end
            exp_rdy = !(i >= 6 && i < 16);
            n_cmp++;
            if (ld_ready !== exp_rdy) begin
                n_err++; $display("FAIL midload_ready cyc %0d got %b required %b", i, ld_ready, exp_rdy);
            end
            ld_valid = (i == 5);
            ld_data  = 32'hFFFF_FFFF;
        end
    endtask

    task automatic test_pending_ignore();
        exp_t got, e;
        logic exp_rdy;
        q.delete();
        do_reset();
        en = 1'b1;
        push_frame('0);
        push_frame(32'h1122_3344);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL pend_ign cyc %0d got %h required %h", i, got, e);
            end
            exp_rdy = !(i >= 2 && i < 16);
            n_cmp++;
            if (ld_ready !== exp_rdy) begin
                n_err++; $display("FAIL pend_ign_ready cyc %0d got %b required %b", i, ld_ready, exp_rdy);
            end
            if (i == 1) begin
                ld_valid = 1'b1; ld_data = 32'h1122_3344;
            end else if (i >= 3 && i < 15) begin
                ld_valid = 1'b1; ld_data = 32'hAAAA_AAAA;
            end else begin
                ld_valid = 1'b0;
            end
        end
    endtask

    task automatic test_enable_drop();
        exp_t got, e;
        q.delete();
        do_reset();
        ld_data = 32'h0804_0201; ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; en = 1'b1;
        push_frame(32'h0804_0201);
        q = q[0:9];
        push_idle(3);
        push_frame(32'h0804_0201);
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL en_drop cyc %0d got %h required %h", i, got, e);
            end
            if (i == 9)  en = 1'b0;
            if (i == 12) en = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        q.delete();
        do_reset();
        ld_data = 32'h0804_0201; ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; en = 1'b1;
        push_frame(32'h0804_0201);
        q = q[0:5];
        push_idle(1);
        push_frame('0);
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            got = {row_sel, col_data, row_idx, frame_start};
            e = q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++; $display("FAIL rst_mid cyc %0d got %h required %h", i, got, e);
            end
            if (i == 5) begin
                rst = 1'b1; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
            end
            if (i == 6) begin
                n_cmp++;
                if (ld_ready !== 1'b1) begin
                    n_err++; $display("FAIL rst_mid_ready got %b required 1", ld_ready);
                end
                rst = 1'b0; ld_valid = 1'b0;
            end
        end
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_end_ready got %b required 1", ld_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midload();
        test_pending_ignore();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of scanned rows (>=2).
REQ-002 SHALL have parameter COLS, default 16, column bits per row (>=1).
REQ-003 SHALL have parameter DWELL, default 1024, row lit time in clk cycles (>=1).
REQ-004 SHALL have parameter BLANK, default 4, dark cycles before each row (>=1).
REQ-005 SHALL define local IW = max(1, clog2(ROWS)).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  scan enable.
REQ-009 ld_valid  in  1  frame load request.
REQ-010 ld_data  in  ROWS*COLS  frame image; row r at bits [r*COLS +: COLS].
REQ-011 ld_ready  out  1  shadow buffer free; combinational, equal to !pending.
REQ-012 row_sel  out  ROWS  one-hot active-high row drive, registered.
REQ-013 col_data  out  COLS  column drive for current row, registered.
REQ-014 row_idx  out  IW  current row index, registered.
REQ-015 frame_start  out  1  one-cycle pulse marking row 0 entry, registered.

Function
REQ-016 SHALL double-buffer: shadow (load side) and active (display side) arrays of ROWS*COLS bits, plus pending flag.
REQ-017 SHALL capture ld_data into shadow and set pending on a cycle with ld_valid && ld_ready; ld_valid while pending=1 SHALL be ignored.
REQ-018 SHALL use FSM states IDLE, BLANK, SHOW with down-counter timer.
REQ-019 IDLE: row_sel=0, col_data=0, row_idx=0; en=1 -> next cycle BLANK, row_idx=0, timer=BLANK-1, frame_start=1.
REQ-020 BLANK: row_sel=0, col_data=active[row_idx]; timer==0 -> SHOW, timer=DWELL-1; else timer-1.
REQ-021 SHOW: row_sel bit row_idx =1 only, col_data=active[row_idx]; timer==0 -> BLANK, timer=BLANK-1, row_idx+1.
REQ-022 row_idx SHALL wrap ROWS-1 -> 0; on wrap frame_start=1 for that one cycle.
REQ-023 Swap: on each transition into BLANK row 0 (IDLE exit or wrap), if pending=1, active<=shadow and pending<=0 in that same edge; ld_ready rises the following cycle.
REQ-024 Load accepted on a swap edge with pending=0 SHALL set pending and be displayed from the next frame, not the current one.
REQ-025 Row period SHALL be exactly BLANK+DWELL cycles; frame period ROWS*(BLANK+DWELL).
REQ-026 At most one row_sel bit SHALL ever be 1; row_sel SHALL be 0 for every BLANK cycle (no ghosting).
REQ-027 en=0 in any state -> next cycle IDLE, all outputs as REQ-019 IDLE; shadow, active, pending retained.
REQ-028 Loads SHALL be accepted in every state including IDLE.

Reset
REQ-029 rst=1 SHALL, at the clock edge, force IDLE, row_sel=0, col_data=0, row_idx=0, frame_start=0, timer=0, pending=0, shadow=0, active=0.
REQ-030 rst SHALL dominate en and ld_valid; load presented with rst=1 SHALL be discarded.
REQ-031 After reset ld_ready SHALL be 1.

Verification (ROWS=4, COLS=8, DWELL=3, BLANK=1)
REQ-032 Load 0x08040201 in IDLE, then en=1 -> frame_start pulse; row 0 shows 0x01 with row_sel=0001 for 3 cycles after 1 blank cycle; rows 1..3 show 0x02,0x04,0x08 with row_sel 0010,0100,1000; period 16 cycles.
REQ-033 Mid-frame load 0xFFFFFFFF during row 1 -> rows 2,3 still show old data; ld_ready=0 until wrap; next frame all rows 0xFF.
REQ-034 Second ld_valid while pending=1 -> ignored, ld_ready stays 0; first image displayed.
REQ-035 en dropped during row 2 SHOW -> next cycle row_sel=0, col_data=0, row_idx=0; re-enable restarts at row 0 with frame_start.
REQ-036 rst pulsed mid-SHOW with ld_valid=1 -> outputs zero next cycle, pending=0, ld_ready=1, en=1 afterwards shows all-zero columns.
REQ-037 Every cycle assertion: popcount(row_sel)<=1 and row_sel=0 whenever state is BLANK or IDLE.
